// File: rtl/mlp_layer_engine_if.sv
// mlp_layer_engine_if: control, configuration and RAM-port bundle for mlp_layer_engine.
// master: engine side. It drives Done, the A/W RAM read requests and the result RAM writes.
// slave:  control FSM / RAM side. It drives Start, the dimensions, act_mode and the RAM read data.
interface mlp_layer_engine_if #(
   parameter int WIDTH       = 8,
   parameter int DIM_BITS    = 8,
   parameter int A_ADDR_BITS = 9,
   parameter int W_ADDR_BITS = 5,
   parameter int R_ADDR_BITS = 8
);
   logic                   Start;
   logic                   Done;
   logic [DIM_BITS-1:0]    num_rows;
   logic [DIM_BITS-1:0]    num_inputs;
   logic [DIM_BITS-1:0]    num_outputs;
   logic                   act_mode;
   logic                   A_read_en;
   logic [A_ADDR_BITS-1:0] A_read_address;
   logic [WIDTH-1:0]       A_read_data_out;
   logic                   W_read_en;
   logic [W_ADDR_BITS-1:0] W_read_address;
   logic [WIDTH-1:0]       W_read_data_out;
   logic                   R_write_en;
   logic [R_ADDR_BITS-1:0] R_write_address;
   logic [WIDTH-1:0]       R_write_data_in;

   modport master (
      input  Start, num_rows, num_inputs, num_outputs, act_mode, A_read_data_out, W_read_data_out,
      output Done, A_read_en, A_read_address, W_read_en, W_read_address,
             R_write_en, R_write_address, R_write_data_in
   );

   modport slave (
      output Start, num_rows, num_inputs, num_outputs, act_mode, A_read_data_out, W_read_data_out,
      input  Done, A_read_en, A_read_address, W_read_en, W_read_address,
             R_write_en, R_write_address, R_write_data_in
   );
endinterface

// File: rtl/mlp_layer_engine.sv
// mlp_layer_engine: fully-connected layer R[r][n] = act(bias[n] + sum_k A[r][k]*W[n][k]).
// Ports: clk, resetn (async, active-low), bus (mlp_layer_engine_if.master) carrying Start/Done,
// the M/K/N/act_mode configuration, the A and W RAM read ports and the result RAM write port.
module mlp_layer_engine #(
   parameter int WIDTH       = 8,
   parameter int DIM_BITS    = 8,
   parameter int A_ADDR_BITS = 9,
   parameter int W_ADDR_BITS = 5,
   parameter int R_ADDR_BITS = 8,
   parameter int ACC_BITS    = 2*WIDTH+DIM_BITS
) (
   input logic                clk,
   input logic                resetn,
   mlp_layer_engine_if.master bus
);
   typedef enum logic [2:0] {IDLE, LOAD_BIAS, MAC, WRITE, DONE} state_t;

   state_t                  state, state_nx;
   logic [DIM_BITS-1:0]     m_q, k_q, n_q, k_cnt, r_cnt, n_cnt;
   logic                    act_q;
   logic [A_ADDR_BITS-1:0]  a_ptr;
   logic [W_ADDR_BITS-1:0]  w_ptr, w_base;
   logic [R_ADDR_BITS-1:0]  r_ptr;
   logic [2*WIDTH-1:0]      prod;
   logic [ACC_BITS-1:0]     acc, bias_ext, prod_ext, sum;
   logic [ACC_BITS-WIDTH-1:0] v;
   logic [WIDTH-1:0]        sat, res;
   logic                    rd, last_k, last_row, last_el, zero_mn, start_run;

   // Data returned by the RAMs belongs to the addresses issued in the previous cycle.
   assign prod     = {{WIDTH{1'b0}}, bus.A_read_data_out} * {{WIDTH{1'b0}}, bus.W_read_data_out};
   assign prod_ext = ACC_BITS'(prod);
   assign bias_ext = ACC_BITS'({bus.W_read_data_out, {WIDTH{1'b0}}});
   // With K=0 the bias arrives during WRITE itself, so it is the whole sum.
   assign sum      = (k_q == '0) ? bias_ext : acc + prod_ext;
   assign v        = sum[ACC_BITS-1:WIDTH];
   assign sat      = |(v >> WIDTH) ? '1 : v[WIDTH-1:0];
   assign res      = act_q ? {WIDTH{sat[WIDTH-1]}} : sat;

   assign last_k    = k_cnt == k_q - 1'b1;
   assign last_row  = r_cnt == m_q - 1'b1;
   assign last_el   = last_row && (n_cnt == n_q - 1'b1);
   assign zero_mn   = (m_q == '0) || (n_q == '0);
   assign start_run = (state == IDLE) && (state_nx == LOAD_BIAS);

   always_ff @(posedge clk or negedge resetn)
      if (!resetn) state <= IDLE;
      else state <= state_nx;

   always_comb begin
      state_nx           = state;
      rd                 = (state == LOAD_BIAS) || (state == MAC);
      bus.A_read_en      = rd;
      bus.W_read_en      = rd;
      bus.A_read_address = rd ? a_ptr : '0;
      bus.W_read_address = rd ? w_ptr : '0;
      case (state)
         IDLE:      state_nx = (bus.Start && !bus.Done) ? LOAD_BIAS : IDLE;
         LOAD_BIAS: state_nx = !bus.Start ? IDLE : zero_mn ? DONE : (k_q == '0) ? WRITE : MAC;
         MAC:       state_nx = !bus.Start ? IDLE : last_k ? WRITE : MAC;
         WRITE:     state_nx = !bus.Start ? IDLE : last_el ? DONE : LOAD_BIAS;
         DONE:      state_nx = bus.Start ? DONE : IDLE;
         default:   state_nx = IDLE;
      endcase
   end

   // Addresses come from running pointers: a_ptr walks A row by row (reset to 0 when a neuron's
   // rows are finished), w_ptr walks bias+weights and rewinds to w_base for every row,
   // r_ptr is simply the element count because R is column-major with rows inner.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         bus.Done            <= 1'b0;
         bus.R_write_en      <= 1'b0;
         bus.R_write_address <= '0;
         bus.R_write_data_in <= '0;
         m_q                 <= '0;
         k_q                 <= '0;
         n_q                 <= '0;
         act_q               <= 1'b0;
         k_cnt               <= '0;
         r_cnt               <= '0;
         n_cnt               <= '0;
         a_ptr               <= '0;
         w_ptr               <= '0;
         w_base              <= '0;
         r_ptr               <= '0;
         acc                 <= '0;
      end else begin
         bus.Done       <= state_nx == DONE;
         bus.R_write_en <= (state == WRITE) && bus.Start;
         if (start_run) begin
            m_q    <= bus.num_rows;
            k_q    <= bus.num_inputs;
            n_q    <= bus.num_outputs;
            act_q  <= bus.act_mode;
            r_cnt  <= '0;
            n_cnt  <= '0;
            a_ptr  <= '0;
            w_ptr  <= '0;
            w_base <= '0;
            r_ptr  <= '0;
         end
         if (state == LOAD_BIAS) begin
            w_ptr <= w_ptr + 1'b1;
            k_cnt <= '0;
         end
         if (state == MAC) begin
            acc   <= (k_cnt == '0) ? bias_ext : acc + prod_ext;
            a_ptr <= a_ptr + 1'b1;
            w_ptr <= w_ptr + 1'b1;
            k_cnt <= k_cnt + 1'b1;
         end
         if ((state == WRITE) && bus.Start) begin
            acc                 <= sum;
            bus.R_write_data_in <= res;
            bus.R_write_address <= r_ptr;
            r_ptr               <= r_ptr + 1'b1;
            r_cnt               <= last_row ? '0 : r_cnt + 1'b1;
            n_cnt               <= last_row ? n_cnt + 1'b1 : n_cnt;
            a_ptr               <= last_row ? '0 : a_ptr;
            w_base              <= last_row ? w_ptr : w_base;
            w_ptr               <= last_row ? w_ptr : w_base;
         end
      end
   end
endmodule

// File: tb/tb_mlp_layer_engine.sv
// tb_mlp_layer_engine: directed self-checking bench for mlp_layer_engine with A/W/R RAM models.
`timescale 1ns/1ps
module tb_mlp_layer_engine;
   logic clk = 1'b0;
   logic resetn;
   always #5 clk = ~clk;

   mlp_layer_engine_if bus ();
   mlp_layer_engine dut (.clk(clk), .resetn(resetn), .bus(bus));

   logic [7:0] a_mem [512];
   logic [7:0] w_mem [32];
   logic [7:0] wr_addr [1024];
   logic [7:0] wr_data [1024];
   int         wr_cyc [1024];
   logic [7:0] k0_exp [6] = '{8'h11, 8'h11, 8'h22, 8'h22, 8'h33, 8'h33};
   int wr_n = 0;
   int cyc = 0;
   int n_tests = 0;
   int n_fail = 0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (bus.A_read_en) bus.A_read_data_out <= a_mem[bus.A_read_address];
      if (bus.W_read_en) bus.W_read_data_out <= w_mem[bus.W_read_address];
      if (bus.R_write_en) begin
         wr_addr[wr_n] <= bus.R_write_address;
         wr_data[wr_n] <= bus.R_write_data_in;
         wr_cyc[wr_n]  <= cyc;
         wr_n          <= wr_n + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_out(input int r, input int n, input int k, input logic mode);
      int acc, v;
      acc = int'(w_mem[n*(k+1)]) * 256;
      for (int j = 0; j < k; j++) acc += int'(a_mem[r*k+j]) * int'(w_mem[n*(k+1)+1+j]);
      v = acc / 256;
      if (v > 255) v = 255;
      if (mode) v = (v >= 128) ? 255 : 0;
      return 32'(v);
   endfunction

   task automatic run(input logic [7:0] m, input logic [7:0] k, input logic [7:0] n,
                      input logic mode, input int limit, output int done_cyc);
      @(negedge clk);
      bus.num_rows    = m;
      bus.num_inputs  = k;
      bus.num_outputs = n;
      bus.act_mode    = mode;
      bus.Start       = 1'b1;
      done_cyc = -1;
      for (int i = 1; i <= limit && done_cyc < 0; i++) begin
         @(posedge clk);
         #1;
         if (bus.Done) done_cyc = i;
      end
   endtask

   task automatic stop_run();
      @(negedge clk);
      bus.Start = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic check_writes(input string tag, input int base, input int cnt,
                               input int m, input int k, input logic mode);
      check({tag, "_nwrites"}, 32'(wr_n - base), 32'(cnt));
      for (int e = 0; e < cnt; e++) begin
         check({tag, "_addr"}, 32'(wr_addr[base+e]), 32'(e));
         check({tag, "_data"}, 32'(wr_data[base+e]), ref_out(e % m, e / m, k, mode));
      end
   endtask

   initial begin
      int d, b;
      resetn          = 1'b0;
      bus.Start       = 1'b0;
      bus.num_rows    = '0;
      bus.num_inputs  = '0;
      bus.num_outputs = '0;
      bus.act_mode    = 1'b0;
      for (int i = 0; i < 512; i++) a_mem[i] = 8'h00;
      for (int i = 0; i < 32; i++) w_mem[i] = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      check("rst_done", 32'(bus.Done), 0);
      check("rst_wen", 32'(bus.R_write_en), 0);
      check("rst_waddr", 32'(bus.R_write_address), 0);
      check("rst_wdata", 32'(bus.R_write_data_in), 0);
      check("rst_aen", 32'(bus.A_read_en), 0);
      check("rst_wren", 32'(bus.W_read_en), 0);
      check("rst_aaddr", 32'(bus.A_read_address), 0);
      @(negedge clk);
      resetn = 1'b1;

      w_mem[0] = 8'h10; w_mem[1] = 8'h80; a_mem[0] = 8'h80;
      b = wr_n;
      run(1, 1, 1, 1'b0, 20, d);
      check("t1_done_cycle", 32'(d), 4);
      check("t1_wen_at_done", 32'(bus.R_write_en), 1);
      check("t1_wdata", 32'(bus.R_write_data_in), 32'h50);
      @(posedge clk);
      #1;
      check("t1_done_held", 32'(bus.Done), 1);
      check("t1_wen_single", 32'(bus.R_write_en), 0);
      stop_run();
      check("t1_done_clear", 32'(bus.Done), 0);
      check("t1_nwrites", 32'(wr_n - b), 1);
      check("t1_addr", 32'(wr_addr[b]), 0);

      b = wr_n;
      run(1, 1, 1, 1'b1, 20, d);
      check("t1s_done_cycle", 32'(d), 4);
      check("t1s_wdata", 32'(bus.R_write_data_in), 32'h00);
      stop_run();

      w_mem[0] = 8'hFF; w_mem[1] = 8'hFF; w_mem[2] = 8'hFF; a_mem[0] = 8'hFF; a_mem[1] = 8'hFF;
      run(1, 2, 1, 1'b0, 20, d);
      check("t2_done_cycle", 32'(d), 5);
      check("t2_sat", 32'(bus.R_write_data_in), 32'hFF);
      stop_run();
      run(1, 2, 1, 1'b1, 20, d);
      check("t2s_step", 32'(bus.R_write_data_in), 32'hFF);
      stop_run();

      w_mem[0] = 8'h11; w_mem[1] = 8'h22; w_mem[2] = 8'h33;
      b = wr_n;
      run(2, 0, 3, 1'b0, 40, d);
      check("k0_done_cycle", 32'(d), 13);
      stop_run();
      check("k0_nwrites", 32'(wr_n - b), 6);
      for (int i = 0; i < 6; i++) begin
         check("k0_addr", 32'(wr_addr[b+i]), 32'(i));
         check("k0_data", 32'(wr_data[b+i]), 32'(k0_exp[i]));
         if (i > 0) check("k0_spacing", 32'(wr_cyc[b+i] - wr_cyc[b+i-1]), 2);
      end

      b = wr_n;
      run(2, 3, 0, 1'b0, 20, d);
      check("n0_done_cycle", 32'(d), 2);
      stop_run();
      run(0, 3, 2, 1'b0, 20, d);
      check("m0_done_cycle", 32'(d), 2);
      stop_run();
      check("zero_dim_nwrites", 32'(wr_n - b), 0);

      for (int i = 0; i < 448; i++) a_mem[i] = 8'($urandom);
      for (int i = 0; i < 16; i++) w_mem[i] = 8'($urandom);
      b = wr_n;
      run(64, 7, 2, 1'b0, 1300, d);
      check("big_done_cycle", 32'(d), 1153);
      check("big_wen_at_done", 32'(bus.R_write_en), 1);
      stop_run();
      check_writes("big", b, 128, 64, 7, 1'b0);

      b = wr_n;
      @(negedge clk);
      bus.num_rows = 8'd3; bus.num_inputs = 8'd4; bus.num_outputs = 8'd2; bus.act_mode = 1'b0;
      bus.Start = 1'b1;
      repeat (28) @(posedge clk);
      #1;
      check("drop_in_mac", 32'(bus.A_read_en), 1);
      @(negedge clk);
      bus.Start = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      check("drop_done", 32'(bus.Done), 0);
      check("drop_no_reads", 32'(bus.A_read_en), 0);
      check_writes("drop", b, 4, 3, 4, 1'b0);
      b = wr_n;
      run(3, 4, 2, 1'b0, 60, d);
      check("restart_done_cycle", 32'(d), 37);
      stop_run();
      check_writes("restart", b, 6, 3, 4, 1'b0);

      @(negedge clk);
      bus.num_rows = 8'd2; bus.num_inputs = 8'd5; bus.num_outputs = 8'd1;
      bus.Start = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check("arst_in_mac", 32'(bus.W_read_en), 1);
      #3;
      resetn = 1'b0;
      #1;
      check("arst_done", 32'(bus.Done), 0);
      check("arst_wen", 32'(bus.R_write_en), 0);
      check("arst_waddr", 32'(bus.R_write_address), 0);
      check("arst_wdata", 32'(bus.R_write_data_in), 0);
      check("arst_aen", 32'(bus.A_read_en), 0);
      check("arst_wren", 32'(bus.W_read_en), 0);
      check("arst_aaddr", 32'(bus.A_read_address), 0);
      check("arst_waddr_rd", 32'(bus.W_read_address), 0);
      bus.Start = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      w_mem[0] = 8'h10; w_mem[1] = 8'h80; a_mem[0] = 8'h80;
      b = wr_n;
      run(1, 1, 1, 1'b0, 20, d);
      check("post_rst_done_cycle", 32'(d), 4);
      check("post_rst_wdata", 32'(bus.R_write_data_in), 32'h50);
      stop_run();
      check("post_rst_nwrites", 32'(wr_n - b), 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
